// File: rtl/re_tq_pkg.sv
// Shared definitions for the level-2 transform controller: size codes,
// beats-per-size table, result latencies and the controller state type.
package re_tq_pkg;

   typedef enum logic [1:0] {
      SZ_4X4   = 2'd0,
      SZ_8X8   = 2'd1,
      SZ_16X16 = 2'd2,
      SZ_32X32 = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int LAT_SHORT = 3;
   localparam int LAT_LONG  = 4;

   localparam logic [6:0] BEATS_TBL [4] = '{7'd1, 7'd4, 7'd16, 7'd64};

   function automatic logic [6:0] beats_m1(input size_e sz);
      return BEATS_TBL[sz] - 7'd1;
   endfunction

   // Only 8x8 uses the short butterfly path.
   function automatic logic is_long(input size_e sz);
      return (sz != SZ_8X8);
   endfunction

endpackage

// File: rtl/re_level2_ctrl_if.sv
// Request / butterfly-control / status bundle of the level-2 controller.
interface re_level2_ctrl_if;
   logic        i_start;
   logic [1:0]  i_size;
   logic        i_inverse;
   logic        i_hold;
   logic        o_ready;
   logic        o_issue;
   logic        o_dt_vld_32;
   logic        o_dt_vld_16;
   logic        o_dt_vld_8;
   logic        o_inverse;
   logic        o_out_vld;
   logic        o_out_last;
   logic        o_done;
   logic [15:0] o_blk_cnt;
   logic [15:0] o_stall_cnt;

   modport slave (
      input  i_start, i_size, i_inverse, i_hold,
      output o_ready, o_issue, o_dt_vld_32, o_dt_vld_16, o_dt_vld_8,
             o_inverse, o_out_vld, o_out_last, o_done, o_blk_cnt, o_stall_cnt
   );

   modport master (
      output i_start, i_size, i_inverse, i_hold,
      input  o_ready, o_issue, o_dt_vld_32, o_dt_vld_16, o_dt_vld_8,
             o_inverse, o_out_vld, o_out_last, o_done, o_blk_cnt, o_stall_cnt
   );
endinterface

// File: rtl/re_level2_lat_pipe.sv
// Valid/last delay line modelling the butterfly latency, tapped at
// LAT_SHORT or LAT_LONG stages.
module re_level2_lat_pipe
   import re_tq_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_vld,
   input  logic i_last,
   input  logic i_long,
   output logic o_vld,
   output logic o_last,
   output logic o_busy
);

   localparam logic [LAT_LONG-1:0] GATE_SHORT = LAT_LONG'((32'd1 << LAT_SHORT) - 32'd1);
   localparam logic [LAT_LONG-1:0] BUSY_SHORT = LAT_LONG'((32'd1 << (LAT_SHORT - 1)) - 32'd1);
   localparam logic [LAT_LONG-1:0] BUSY_LONG  = LAT_LONG'((32'd1 << (LAT_LONG - 1)) - 32'd1);

   logic [LAT_LONG-1:0] r_v;
   logic [LAT_LONG-1:0] r_l;
   logic [LAT_LONG-1:0] w_gate;
   logic [LAT_LONG-1:0] w_busy_mask;

   // Short blocks never populate stages past their tap, so the pipe drains clean.
   always_comb begin
      w_gate      = {LAT_LONG{1'b1}};
      w_busy_mask = BUSY_LONG;
      if (i_long) begin
         w_gate      = {LAT_LONG{1'b1}};
         w_busy_mask = BUSY_LONG;
      end else begin
         w_gate      = GATE_SHORT;
         w_busy_mask = BUSY_SHORT;
      end
   end

   // Shift register of in-flight results
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_v <= {LAT_LONG{1'b0}};
         r_l <= {LAT_LONG{1'b0}};
      end else begin
         r_v <= {r_v[LAT_LONG-2:0], i_vld} & w_gate;
         r_l <= {r_l[LAT_LONG-2:0], i_vld & i_last} & w_gate;
      end
   end

   assign o_vld  = i_long ? r_v[LAT_LONG-1] : r_v[LAT_SHORT-1];
   assign o_last = i_long ? r_l[LAT_LONG-1] : r_l[LAT_SHORT-1];
   assign o_busy = |(r_v & w_busy_mask);

endmodule

// File: rtl/re_level2_ctrl.sv
// Level-2 butterfly issue controller: IDLE/ISSUE/DRAIN sequencing of block beats.
// Optional perf counters are built when RE_LEVEL2_CTRL_PERF_EN is defined.
module re_level2_ctrl
   import re_tq_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   re_level2_ctrl_if.slave bus
);

   state_e     r_state;
   state_e     w_state_nxt;
   size_e      r_size;
   logic       r_inverse;
   logic [6:0] r_beat_cnt;
   size_e      w_req_size;
   logic       w_long;
   logic       w_issue;
   logic       w_last_beat;
   logic       w_ready;
   logic       w_accept;
   logic       w_out_vld;
   logic       w_out_last;
   logic       w_busy;
   logic       w_done;

   assign w_req_size = size_e'(bus.i_size);
   assign w_long     = is_long(r_size);

   // Back-to-back acceptance only when direction and latency class match, so outputs never collide.
   always_comb begin
      w_issue     = 1'b0;
      w_last_beat = 1'b0;
      w_ready     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_ready = 1'b1;
         end
         ST_ISSUE: begin
            w_issue     = !bus.i_hold;
            w_last_beat = w_issue && (r_beat_cnt == beats_m1(r_size));
            w_ready     = w_last_beat && (bus.i_inverse == r_inverse)
                          && (is_long(w_req_size) == w_long);
         end
         default: begin
            w_ready = 1'b0;
         end
      endcase
      w_accept = bus.i_start && w_ready;
   end

   // Next-state selection
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_state_nxt = ST_ISSUE;
            else          w_state_nxt = ST_IDLE;
         end
         ST_ISSUE: begin
            if (w_last_beat && !w_accept) w_state_nxt = ST_DRAIN;
            else                          w_state_nxt = ST_ISSUE;
         end
         ST_DRAIN: begin
            if (!w_busy) w_state_nxt = ST_IDLE;
            else         w_state_nxt = ST_DRAIN;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, beat counter and attributes latched at accept
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_size     <= SZ_4X4;
         r_inverse  <= 1'b0;
         r_beat_cnt <= 7'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_size     <= w_req_size;
            r_inverse  <= bus.i_inverse;
            r_beat_cnt <= 7'd0;
         end else if (w_issue) begin
            r_beat_cnt <= r_beat_cnt + 7'd1;
         end else begin
            r_beat_cnt <= r_beat_cnt;
         end
      end
   end

   re_level2_lat_pipe u_lat_pipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_vld  (w_issue),
      .i_last (w_last_beat),
      .i_long (w_long),
      .o_vld  (w_out_vld),
      .o_last (w_out_last),
      .o_busy (w_busy)
   );

   assign w_done          = w_out_vld & w_out_last;
   assign bus.o_ready     = w_ready;
   assign bus.o_issue     = w_issue;
   assign bus.o_dt_vld_32 = w_issue && (r_size == SZ_32X32);
   assign bus.o_dt_vld_16 = w_issue && (r_size == SZ_16X16);
   assign bus.o_dt_vld_8  = w_issue && (r_size == SZ_8X8);
   assign bus.o_inverse   = r_inverse;
   assign bus.o_out_vld   = w_out_vld;
   assign bus.o_out_last  = w_done;
   assign bus.o_done      = w_done;

`ifdef RE_LEVEL2_CTRL_PERF_EN
   logic [15:0] r_blk_cnt;
   logic [15:0] r_stall_cnt;

   // Completed-block and hold-stall counters, wrapping at 16 bits
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_blk_cnt   <= 16'd0;
         r_stall_cnt <= 16'd0;
      end else begin
         if (w_done) r_blk_cnt <= r_blk_cnt + 16'd1;
         else        r_blk_cnt <= r_blk_cnt;
         if ((r_state == ST_ISSUE) && bus.i_hold) r_stall_cnt <= r_stall_cnt + 16'd1;
         else                                     r_stall_cnt <= r_stall_cnt;
      end
   end

   assign bus.o_blk_cnt   = r_blk_cnt;
   assign bus.o_stall_cnt = r_stall_cnt;
`else
   assign bus.o_blk_cnt   = 16'd0;
   assign bus.o_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_re_level2_ctrl.sv
// Directed bench for re_level2_ctrl: per-cycle vector table plus multi-block sequences.
module tb_re_level2_ctrl;

   logic clk = 1'b0;
   logic rst_n;

   re_level2_ctrl_if bus ();

   re_level2_ctrl u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

`ifdef RE_LEVEL2_CTRL_PERF_EN
   localparam int PERF = 1;
`else
   localparam int PERF = 0;
`endif

   // exp = {ready, issue, dt32, dt16, dt8, inverse, out_vld, out_last, done}
   typedef struct packed {
      logic       start;
      logic [1:0] size;
      logic       inv;
      logic       hold;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs [18];

   int   n_pass  = 0;
   int   n_total = 0;
   int   cyc     = 0;
   int   n_bad_dt = 0;
   int   n_dt16  = 0;
   logic prev_inv = 1'b0;
   int   issue_q[$];
   int   vld_q[$];
   int   last_q[$];
   int   done_q[$];
   int   acc_q[$];
   int   inv_chg_q[$];

   function automatic vec_t mk(input logic s, input logic [1:0] z, input logic iv,
                               input logic h, input logic [8:0] e);
      vec_t v;
      v.start = s;
      v.size  = z;
      v.inv   = iv;
      v.hold  = h;
      v.exp   = e;
      return v;
   endfunction

   function automatic logic [8:0] outs();
      return {bus.o_ready, bus.o_issue, bus.o_dt_vld_32, bus.o_dt_vld_16, bus.o_dt_vld_8,
              bus.o_inverse, bus.o_out_vld, bus.o_out_last, bus.o_done};
   endfunction

   // Event log, sampled away from the active edge
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (bus.o_issue === 1'b1) issue_q.push_back(cyc);
      if (bus.o_out_vld === 1'b1) vld_q.push_back(cyc);
      if (bus.o_out_last === 1'b1) last_q.push_back(cyc);
      if (bus.o_done === 1'b1) done_q.push_back(cyc);
      if ((bus.i_start === 1'b1) && (bus.o_ready === 1'b1)) acc_q.push_back(cyc);
      if (bus.o_dt_vld_16 === 1'b1) n_dt16++;
      if (bus.o_inverse !== prev_inv) inv_chg_q.push_back(cyc);
      prev_inv = bus.o_inverse;
      if ((32'(bus.o_dt_vld_32 === 1'b1) + 32'(bus.o_dt_vld_16 === 1'b1) + 32'(bus.o_dt_vld_8 === 1'b1))
          > ((bus.o_issue === 1'b1) ? 32'd1 : 32'd0)) n_bad_dt++;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic clear_log();
      issue_q.delete();
      vld_q.delete();
      last_q.delete();
      done_q.delete();
      acc_q.delete();
      inv_chg_q.delete();
      n_dt16 = 0;
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
   task automatic request(input logic [1:0] sz, input logic inv, input string nm);
      bit got;
      got = 1'b0;
      bus.i_start   = 1'b1;
      bus.i_size    = sz;
      bus.i_inverse = inv;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (bus.o_ready === 1'b1) got = 1'b1;
         else got = 1'b0;
      end
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      chk({"accept_", nm}, int'(got), 1);
   endtask

   task automatic wait_done(input int n, input int budget);
      for (int i = 0; i < budget && done_q.size() < n; i++) begin
         @(negedge clk);
         #1;
      end
      chk("done_pulses", done_q.size(), n);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.i_start   = 1'b0;
      bus.i_size    = 2'd0;
      bus.i_inverse = 1'b0;
      bus.i_hold    = 1'b0;

      // Single 4x4 forward block
      vecs[0]  = mk(1'b1, 2'd0, 1'b0, 1'b0, 9'b100000000);
      vecs[1]  = mk(1'b0, 2'd0, 1'b1, 1'b0, 9'b010000000);
      vecs[2]  = mk(1'b0, 2'd0, 1'b0, 1'b0, 9'b000000000);
      vecs[3]  = mk(1'b0, 2'd0, 1'b0, 1'b0, 9'b000000000);
      vecs[4]  = mk(1'b0, 2'd0, 1'b0, 1'b0, 9'b000000000);
      vecs[5]  = mk(1'b0, 2'd0, 1'b0, 1'b0, 9'b000000111);
      vecs[6]  = mk(1'b0, 2'd0, 1'b0, 1'b0, 9'b100000000);
      // 8x8 inverse with hold in its 2nd and 3rd cycles
      vecs[7]  = mk(1'b1, 2'd1, 1'b1, 1'b0, 9'b100000000);
      vecs[8]  = mk(1'b0, 2'd1, 1'b0, 1'b0, 9'b010011000);
      vecs[9]  = mk(1'b0, 2'd1, 1'b0, 1'b1, 9'b000001000);
      vecs[10] = mk(1'b0, 2'd1, 1'b0, 1'b1, 9'b000001000);
      vecs[11] = mk(1'b0, 2'd1, 1'b0, 1'b0, 9'b010011100);
      vecs[12] = mk(1'b0, 2'd1, 1'b0, 1'b0, 9'b010011000);
      vecs[13] = mk(1'b0, 2'd1, 1'b0, 1'b0, 9'b010011000);
      vecs[14] = mk(1'b0, 2'd1, 1'b0, 1'b0, 9'b000001100);
      vecs[15] = mk(1'b0, 2'd1, 1'b0, 1'b0, 9'b000001100);
      vecs[16] = mk(1'b0, 2'd1, 1'b0, 1'b0, 9'b000001111);
      vecs[17] = mk(1'b0, 2'd0, 1'b0, 1'b0, 9'b100001000);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", int'(outs()), int'(9'b100000000));
      chk("reset_blk_cnt", int'(bus.o_blk_cnt), 0);
      chk("reset_stall_cnt", int'(bus.o_stall_cnt), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         @(posedge clk);
         #1;
         bus.i_start   = vecs[i].start;
         bus.i_size    = vecs[i].size;
         bus.i_inverse = vecs[i].inv;
         bus.i_hold    = vecs[i].hold;
         @(negedge clk);
         chk($sformatf("vec%0d", i), int'(outs()), int'(vecs[i].exp));
      end
      chk("blk_cnt_after_2", int'(bus.o_blk_cnt), 2 * PERF);
      chk("stall_cnt_hold2", int'(bus.o_stall_cnt), 2 * PERF);

      // Two 16x16 forward blocks back-to-back
      @(posedge clk);
      #1;
      clear_log();
      request(2'd2, 1'b0, "b2b_a");
      request(2'd2, 1'b0, "b2b_b");
      wait_done(2, 200);
      chk("b2b_issue_cnt", issue_q.size(), 32);
      chk("b2b_issue_span", (issue_q.size() == 32) ? issue_q[31] - issue_q[0] : -1, 31);
      chk("b2b_dt16_cnt", n_dt16, 32);
      chk("b2b_vld_cnt", vld_q.size(), 32);
      chk("b2b_vld_span", (vld_q.size() == 32) ? vld_q[31] - vld_q[0] : -1, 31);
      chk("b2b_latency", (vld_q.size() > 0 && issue_q.size() > 0) ? vld_q[0] - issue_q[0] : -1, 4);
      chk("b2b_done_gap", (done_q.size() == 2) ? done_q[1] - done_q[0] : -1, 16);

      // 32x32 forward then 32x32 inverse
      clear_log();
      request(2'd3, 1'b0, "dir_a");
      request(2'd3, 1'b1, "dir_b");
      wait_done(2, 400);
      chk("dir_vld_cnt", vld_q.size(), 128);
      chk("dir_acc_after_last", (acc_q.size() == 2 && done_q.size() > 0) ? int'(acc_q[1] > done_q[0]) : 0, 1);
      chk("dir_inv_changes", inv_chg_q.size(), 1);
      chk("dir_inv_when", (inv_chg_q.size() > 0 && acc_q.size() == 2) ? inv_chg_q[0] - acc_q[1] : -1, 1);

      // 8x8 then 16x16, same direction: different latency class
      clear_log();
      request(2'd1, 1'b0, "mix_a");
      request(2'd2, 1'b0, "mix_b");
      wait_done(2, 200);
      chk("mix_last_cnt", last_q.size(), 2);
      chk("mix_vld_cnt", vld_q.size(), 20);
      chk("mix_drain_gap", (acc_q.size() == 2 && done_q.size() > 0) ? int'(acc_q[1] > done_q[0]) : 0, 1);
      chk("mix_second_lat", (acc_q.size() == 2 && vld_q.size() == 20) ? vld_q[4] - acc_q[1] : -1, 5);

      // Reset during the 20th beat of a 32x32 block
      clear_log();
      request(2'd3, 1'b0, "rst_blk");
      repeat (19) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      #1;
      chk("rst_mid_outs", int'(outs()), int'(9'b100000000));
      chk("rst_mid_beats", issue_q.size(), 20);
      chk("rst_mid_blk_cnt", int'(bus.o_blk_cnt), 0);
      chk("rst_mid_stall_cnt", int'(bus.o_stall_cnt), 0);
      rst_n = 1'b1;
      clear_log();
      repeat (10) @(posedge clk);
      #1;
      chk("rst_no_vld", vld_q.size(), 0);
      chk("rst_no_done", done_q.size(), 0);

      chk("dt_strobe_rule", n_bad_dt, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
